client_mem_bridge: RTL and testbench

- Byte-serial host command port that drives the client side of the data memory (ClientMemAddr/ClientMemWrite/CWDM/CRDM) and returns read data.
- Sits between the host link byte receiver/transmitter and the data memory.
- Assembles a command, address and write payload from an input byte stream, then issues a single one-cycle memory access.
- Streams the read data or an ack/nak byte back on an output byte stream.

---
 rtl/client_mem_bridge_pkg.sv | 34 +++
 rtl/client_mem_bridge_byte_shift_reg.sv | 34 +++
 rtl/client_mem_bridge.sv | 221 ++++++++++++++++++++++
 tb/tb_client_mem_bridge.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/client_mem_bridge_pkg.sv
// Shared definitions for the host-to-data-memory bridge: access sizes, command
// byte layout, FSM states and the size-to-byte-count helper.
package client_mem_bridge_pkg;

    localparam logic [1:0] SZ_NONE = 2'd0;
    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;
    localparam logic [1:0] SZ_WORD = 2'd3;

    localparam int CMD_WR_BIT = 7;
    localparam int CMD_SZ_LSB = 0;
    localparam int CMD_SZ_MSB = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_DATA    = 3'd2,
        ST_WR      = 3'd3,
        ST_RD_REQ  = 3'd4,
        ST_RD_WAIT = 3'd5,
        ST_SEND    = 3'd6,
        ST_RESP    = 3'd7
    } state_t;

    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/client_mem_bridge_byte_shift_reg.sv
// 32-bit little-endian byte register: parallel load, indexed byte insert for
// assembly, and right shift by one byte for LSB-first serialisation.
module client_mem_bridge_byte_shift_reg
    import client_mem_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [31:0] i_load_data,
    input  logic        i_shift_in,
    input  logic [1:0]  i_idx,
    input  logic [7:0]  i_byte,
    input  logic        i_shift_out,
    output logic [31:0] o_data
);

    logic [31:0] r_data;

    // Load has priority over byte insert, which has priority over shift-out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= 32'h0000_0000;
        end else if (i_load) begin
            r_data <= i_load_data;
        end else if (i_shift_in) begin
            r_data[{i_idx, 3'b000} +: 8] <= i_byte;
        end else if (i_shift_out) begin
            r_data <= {8'h00, r_data[31:8]};
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/client_mem_bridge.sv
// Byte-serial host command port: collects command/address/payload bytes, issues
// one single-cycle data-memory access and streams back read data or ack/nak.
module client_mem_bridge
    import client_mem_bridge_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1000,
    parameter logic [7:0] ACK_BYTE       = 8'h06,
    parameter logic [7:0] NAK_BYTE       = 8'h15
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [7:0]  InData,
    input  logic        InValid,
    output logic        InReady,
    output logic [7:0]  OutData,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] ClientMemAddr,
    output logic [31:0] ClientMemWrite,
    output logic [1:0]  CWDM,
    output logic [1:0]  CRDM,
    input  logic [31:0] ClientMemRead,
    output logic        Busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t      r_state;
    logic        r_wr;
    logic [1:0]  r_size;
    logic [2:0]  r_cnt;
    logic [TW-1:0] r_tmo;
    logic [31:0] r_addr;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [7:0]  r_out_data;
    logic [1:0]  r_cwdm;
    logic [1:0]  r_crdm;
    logic        r_busy;

    logic        w_in_xfer;
    logic        w_out_xfer;
    logic [2:0]  w_nbytes;
    logic        w_tmo_hit;
    logic [1:0]  w_cmd_size;
    logic [31:0] w_wd_data;
    logic [31:0] w_rd_data;
    logic [15:0] w_rd_unused;

    assign w_in_xfer  = InValid && r_in_ready;
    assign w_out_xfer = r_out_valid && OutReady;
    assign w_nbytes   = size_to_bytes(r_size);
    assign w_tmo_hit  = (r_tmo == TW'(TIMEOUT_CYCLES - 1));
    assign w_cmd_size = InData[CMD_SZ_MSB:CMD_SZ_LSB];
    assign w_rd_unused = {w_rd_data[31:16], w_rd_data[7:0]};

    // Write payload: cleared when a command is latched so unused upper bytes read 0.
    client_mem_bridge_byte_shift_reg u_wr_asm (
        .clk         (Clk),
        .rst_n       (Rst),
        .i_load      ((r_state == ST_IDLE) && w_in_xfer),
        .i_load_data (32'h0000_0000),
        .i_shift_in  ((r_state == ST_DATA) && w_in_xfer),
        .i_idx       (r_cnt[1:0]),
        .i_byte      (InData),
        .i_shift_out (1'b0),
        .o_data      (w_wd_data)
    );

    // Read data: OutData holds byte 0 while bits [15:8] are the next byte to send.
    client_mem_bridge_byte_shift_reg u_rd_ser (
        .clk         (Clk),
        .rst_n       (Rst),
        .i_load      (r_state == ST_RD_WAIT),
        .i_load_data (ClientMemRead),
        .i_shift_in  (1'b0),
        .i_idx       (2'd0),
        .i_byte      (8'h00),
        .i_shift_out ((r_state == ST_SEND) && w_out_xfer),
        .o_data      (w_rd_data)
    );

    // Command FSM; every handshake and strobe output is a register set on entry to its state.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state     <= ST_IDLE;
            r_wr        <= 1'b0;
            r_size      <= SZ_NONE;
            r_cnt       <= 3'd0;
            r_tmo       <= '0;
            r_addr      <= 32'h0000_0000;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_cwdm      <= SZ_NONE;
            r_crdm      <= SZ_NONE;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_in_xfer) begin
                        r_wr   <= InData[CMD_WR_BIT];
                        r_size <= w_cmd_size;
                        r_cnt  <= 3'd0;
                        r_tmo  <= '0;
                        r_busy <= 1'b1;
                        if (w_cmd_size == SZ_NONE) begin
                            r_state     <= ST_RESP;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_data  <= NAK_BYTE;
                        end else begin
                            r_state <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_in_xfer) begin
                        r_addr[{r_cnt[1:0], 3'b000} +: 8] <= InData;
                        r_tmo <= '0;
                        if (r_cnt == 3'd3) begin
                            r_cnt <= 3'd0;
                            if (r_wr) begin
                                r_state <= ST_DATA;
                            end else begin
                                r_state    <= ST_RD_REQ;
                                r_crdm     <= r_size;
                                r_in_ready <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end else if (w_tmo_hit) begin
                        r_state     <= ST_RESP;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= NAK_BYTE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_in_xfer) begin
                        r_tmo <= '0;
                        if (r_cnt == (w_nbytes - 3'd1)) begin
                            r_cnt      <= 3'd0;
                            r_state    <= ST_WR;
                            r_cwdm     <= r_size;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end else if (w_tmo_hit) begin
                        r_state     <= ST_RESP;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= NAK_BYTE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_WR: begin
                    r_cwdm      <= SZ_NONE;
                    r_state     <= ST_RESP;
                    r_out_valid <= 1'b1;
                    r_out_data  <= ACK_BYTE;
                end
                ST_RD_REQ: begin
                    r_crdm  <= SZ_NONE;
                    r_state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    r_out_data  <= ClientMemRead[7:0];
                    r_out_valid <= 1'b1;
                    r_cnt       <= 3'd0;
                    r_state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_out_xfer) begin
                        if (r_cnt == (w_nbytes - 3'd1)) begin
                            r_cnt       <= 3'd0;
                            r_state     <= ST_IDLE;
                            r_out_valid <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_cnt      <= r_cnt + 3'd1;
                            r_out_data <= w_rd_data[15:8];
                        end
                    end
                end
                ST_RESP: begin
                    if (w_out_xfer) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_cwdm      <= SZ_NONE;
                    r_crdm      <= SZ_NONE;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign InReady        = r_in_ready;
    assign OutValid       = r_out_valid;
    assign OutData        = r_out_data;
    assign ClientMemAddr  = r_addr;
    assign ClientMemWrite = w_wd_data;
    assign CWDM           = r_cwdm;
    assign CRDM           = r_crdm;
    assign Busy           = r_busy;

endmodule

// File: tb/tb_client_mem_bridge.sv
// Bench for client_mem_bridge: directed scenarios plus random traffic checked
// against a byte-array reference memory kept by the bench.
module tb_client_mem_bridge;

    localparam int TMO = 20;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [7:0]  InData;
    logic        InValid;
    logic        InReady;
    logic [7:0]  OutData;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] ClientMemAddr;
    logic [31:0] ClientMemWrite;
    logic [1:0]  CWDM;
    logic [1:0]  CRDM;
    logic [31:0] ClientMemRead = 32'h0;
    logic        Busy;

    always #5 Clk = ~Clk;

    client_mem_bridge #(.TIMEOUT_CYCLES(TMO), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)) dut (
        .Clk(Clk), .Rst(Rst), .InData(InData), .InValid(InValid), .InReady(InReady),
        .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady),
        .ClientMemAddr(ClientMemAddr), .ClientMemWrite(ClientMemWrite),
        .CWDM(CWDM), .CRDM(CRDM), .ClientMemRead(ClientMemRead), .Busy(Busy)
    );

    bit [7:0] mem     [65536];
    bit [7:0] ref_mem [65536];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0, wr_pulses = 0, rd_pulses = 0, out_xfers = 0;
    int last_in_cyc = 0, wr_cyc = 0, rd_cyc = 0, ov_cyc = 0;
    logic [31:0] wr_addr = 32'h0, wr_data = 32'h0, rd_addr = 32'h0;
    logic [1:0]  wr_size = 2'd0, rd_size = 2'd0;
    logic        prev_ov = 1'b0;

    function automatic int nb(input logic [1:0] s);
        return (s == 2'd3) ? 4 : int'(s);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [1:0] s);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < nb(s); i++) v[8*i +: 8] = mem[a[15:0] + 16'(i)];
        return v;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a, input logic [1:0] s);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < nb(s); i++) v[8*i +: 8] = ref_mem[a[15:0] + 16'(i)];
        return v;
    endfunction

    // Data memory model and strobe/handshake monitor.
    always @(posedge Clk) begin
        cyc     <= cyc + 1;
        prev_ov <= OutValid;
        if (InValid && InReady) last_in_cyc <= cyc;
        if (OutValid && OutReady) out_xfers <= out_xfers + 1;
        if (OutValid && !prev_ov) ov_cyc <= cyc;
        if (CWDM != 2'd0) begin
            wr_pulses <= wr_pulses + 1;
            wr_cyc    <= cyc;
            wr_addr   <= ClientMemAddr;
            wr_data   <= ClientMemWrite;
            wr_size   <= CWDM;
            for (int i = 0; i < 4; i++)
                if (i < nb(CWDM)) mem[ClientMemAddr[15:0] + 16'(i)] <= ClientMemWrite[8*i +: 8];
        end
        if (CRDM != 2'd0) begin
            rd_pulses     <= rd_pulses + 1;
            rd_cyc        <= cyc;
            rd_addr       <= ClientMemAddr;
            rd_size       <= CRDM;
            ClientMemRead <= mem_word(ClientMemAddr, CRDM);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        InData  = b;
        InValid = 1'b1;
        while (!InReady && n < 50) begin @(negedge Clk); n++; end
        check("in_ready_wait", 32'(n < 50), 32'd1);
        @(negedge Clk);
        InValid = 1'b0;
    endtask

    task automatic recv_byte(output logic [7:0] b, input int stall);
        int n = 0;
        logic [7:0] h;
        OutReady = 1'b0;
        while (!OutValid && n < 200) begin @(negedge Clk); n++; end
        check("out_valid_wait", 32'(n < 200), 32'd1);
        h = OutData;
        for (int i = 0; i < stall; i++) begin
            @(negedge Clk);
            check("stall_hold", {23'd0, OutValid, OutData}, {23'd0, 1'b1, h});
        end
        b = OutData;
        OutReady = 1'b1;
        @(negedge Clk);
        OutReady = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int w0 = wr_pulses;
        logic [7:0] r;
        logic [31:0] m;
        m = (sz == 2'd3) ? 32'hFFFF_FFFF : ((sz == 2'd2) ? 32'h0000_FFFF : 32'h0000_00FF);
        send_byte({1'b1, 5'($urandom), sz});
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        for (int i = 0; i < nb(sz); i++) send_byte(d[8*i +: 8]);
        recv_byte(r, int'($urandom_range(0, 2)));
        check("wr_ack", {24'd0, r}, 32'h06);
        check("wr_pulses", 32'(wr_pulses - w0), 32'd1);
        check("wr_addr", wr_addr, a);
        check("wr_size", {30'd0, wr_size}, {30'd0, sz});
        check("wr_data", wr_data, d & m);
        check("wr_latency", 32'(wr_cyc - last_in_cyc), 32'd1);
        check("wr_idle", {31'd0, Busy}, 32'd0);
        for (int i = 0; i < nb(sz); i++) ref_mem[a[15:0] + 16'(i)] = d[8*i +: 8];
    endtask

    task automatic do_read(input logic [1:0] sz, input logic [31:0] a, input int first_stall,
                           input bit rnd, output logic [31:0] got);
        int r0 = rd_pulses;
        int x0 = out_xfers;
        logic [7:0] b;
        got = 32'h0;
        send_byte({1'b0, 5'($urandom), sz});
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        for (int i = 0; i < nb(sz); i++) begin
            recv_byte(b, (i == 0) ? first_stall : (rnd ? int'($urandom_range(0, 3)) : 0));
            got[8*i +: 8] = b;
        end
        check("rd_data", got, ref_word(a, sz));
        check("rd_pulses", 32'(rd_pulses - r0), 32'd1);
        check("rd_addr", rd_addr, a);
        check("rd_size", {30'd0, rd_size}, {30'd0, sz});
        check("rd_latency", 32'(ov_cyc - rd_cyc), 32'd2);
        check("rd_xfers", 32'(out_xfers - x0), 32'(nb(sz)));
        check("rd_idle", {31'd0, Busy}, 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_inready"}, {31'd0, InReady}, 32'd1);
        check({tag, "_outvalid"}, {31'd0, OutValid}, 32'd0);
        check({tag, "_outdata"}, {24'd0, OutData}, 32'd0);
        check({tag, "_busy"}, {31'd0, Busy}, 32'd0);
        check({tag, "_strobes"}, {28'd0, CWDM, CRDM}, 32'd0);
        check({tag, "_addr"}, ClientMemAddr, 32'd0);
        check({tag, "_wdata"}, ClientMemWrite, 32'd0);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] d;
        logic [7:0]  r;
        int w0, r0, n;

        Rst = 1'b0; InValid = 1'b0; InData = 8'h00; OutReady = 1'b0;
        repeat (3) @(negedge Clk);
        check_reset_values("reset");
        Rst = 1'b1;
        @(negedge Clk);

        // Word write, byte read, stalled word read.
        do_write(2'd3, 32'h0000_8000, 32'h1234_5678);
        check("tp_mem_word", mem_word(32'h8000, 2'd3), 32'h1234_5678);
        do_read(2'd1, 32'h0000_8001, 0, 1'b0, got);
        check("tp_byte_read", got, 32'h56);
        do_read(2'd3, 32'h0000_8000, 10, 1'b1, got);
        check("tp_word_read", got, 32'h1234_5678);

        // Invalid size-0 command gets NAK and no memory activity.
        w0 = wr_pulses; r0 = rd_pulses;
        send_byte(8'h80);
        recv_byte(r, 3);
        check("inv_nak", {24'd0, r}, 32'h15);
        check("inv_no_strobe", 32'((wr_pulses - w0) + (rd_pulses - r0)), 32'd0);
        check("inv_idle", {31'd0, Busy}, 32'd0);

        // Timeout mid-address after known contents at 0x9000.
        do_write(2'd2, 32'h0000_9000, $urandom);
        w0 = wr_pulses;
        send_byte(8'h82); send_byte(8'h00); send_byte(8'h90);
        n = 0;
        while (!OutValid && n < 100) begin @(negedge Clk); n++; end
        check("tmo_cycles", 32'(n), 32'(TMO));
        recv_byte(r, 0);
        check("tmo_nak", {24'd0, r}, 32'h15);
        check("tmo_no_wr", 32'(wr_pulses - w0), 32'd0);
        do_read(2'd2, 32'h0000_9000, 0, 1'b0, got);

        // Reset during the data phase of a half write.
        do_write(2'd2, 32'h0000_8100, $urandom);
        w0 = wr_pulses;
        d = $urandom;
        send_byte(8'h82);
        send_byte(8'h00); send_byte(8'h81); send_byte(8'h00); send_byte(8'h00);
        send_byte(d[7:0]);
        Rst = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        check("midrst_no_wr", 32'(wr_pulses - w0), 32'd0);
        do_read(2'd2, 32'h0000_8100, 0, 1'b0, got);

        // Random traffic over a small address window.
        for (int k = 0; k < 40; k++) begin
            int op;
            logic [1:0] sz;
            logic [31:0] a;
            op = int'($urandom_range(0, 9));
            sz = 2'($urandom_range(1, 3));
            a  = 32'h8200 + 32'($urandom_range(0, 63));
            if (op == 0) begin
                w0 = wr_pulses; r0 = rd_pulses;
                send_byte({1'($urandom), 5'($urandom), 2'b00});
                recv_byte(r, int'($urandom_range(0, 3)));
                check("rnd_nak", {24'd0, r}, 32'h15);
                check("rnd_nak_quiet", 32'((wr_pulses - w0) + (rd_pulses - r0)), 32'd0);
            end else if (op < 5) begin
                do_write(sz, a, $urandom);
            end else begin
                do_read(sz, a, int'($urandom_range(0, 3)), 1'b1, got);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
